// File: rtl/sample_frame_tx_if.sv
// Bus bundle between a frame source/controller and sample_frame_tx:
// buffer write port, launch control, downstream response and status outputs.
interface sample_frame_tx_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned FRAME_LEN = 64
);
  localparam int unsigned AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic                 i_wr_en;
  logic [AW-1:0]        i_wr_addr;
  logic [BIT_WIDTH-1:0] i_wr_data;
  logic                 i_start;
  logic [1:0]           i_mode;
  logic                 i_resp_start;
  logic [BIT_WIDTH-1:0] o_data;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_timeout;

  // Controller side: drives the buffer and launch inputs, observes status.
  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_mode, i_resp_start,
    input  o_data, o_busy, o_done, o_timeout
  );

  // Transmitter side.
  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_mode, i_resp_start,
    output o_data, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/sample_frame_tx.sv
// Frame transmitter: buffers FRAME_LEN samples, then on launch sends a mode
// command word followed by the whole frame on a registered bus, and waits
// (bounded by RESP_TIMEOUT cycles) for the downstream start-bit response.
module sample_frame_tx #(
  parameter int unsigned BIT_WIDTH    = 16,
  parameter int unsigned FRAME_LEN    = 64,
  parameter int unsigned RESP_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  sample_frame_tx_if.slave  bus
);
  localparam int unsigned AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned WW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_SAMPLE = AW'(FRAME_LEN - 1);
  localparam logic [WW-1:0] LAST_WAIT   = WW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_SEND,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        samp_cnt_q, samp_cnt_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 timeout_q, timeout_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [BIT_WIDTH-1:0] mem_q [FRAME_LEN];

  // Frame buffer: no reset, writes accepted only while idle.
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en && !busy_q) begin
      mem_q[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      wait_cnt_q <= '0;
      mode_q     <= '0;
      timeout_q  <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mode_q     <= mode_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output decode. The bus word is built from the
  // current state, so it trails the state register by one cycle: command
  // word appears one edge after CMD is entered, sample n one edge after
  // the counter points at it.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mode_d     = mode_q;
    timeout_d  = timeout_q;
    data_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start && (bus.i_mode != 2'b00)) begin
          state_d   = S_CMD;
          mode_d    = bus.i_mode;
          timeout_d = 1'b0;
        end
      end

      S_CMD: begin
        data_d     = BIT_WIDTH'(mode_q);
        samp_cnt_d = '0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        data_d     = mem_q[samp_cnt_q];
        samp_cnt_d = samp_cnt_q + 1'b1;
        if (samp_cnt_q == LAST_SAMPLE) begin
          samp_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = S_WAIT_RESP;
        end
      end

      S_WAIT_RESP: begin
        if (bus.i_resp_start) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        wait_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.o_data    = data_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_sample_frame_tx.sv
// Directed bench for sample_frame_tx with default parameters.
module tb_sample_frame_tx;
  logic clk = 1'b0;
  logic rstb;
  int   errors = 0;
  int   checks = 0;
  int   cnt;
  logic seen_done;

  always #5 clk = ~clk;

  sample_frame_tx_if #(.BIT_WIDTH(16), .FRAME_LEN(64)) bus ();

  sample_frame_tx #(
    .BIT_WIDTH(16),
    .FRAME_LEN(64),
    .RESP_TIMEOUT(1024)
  ) dut (
    .i_clk (clk),
    .i_rstb(rstb),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstb             = 1'b0;
    bus.i_wr_en      = 1'b0;
    bus.i_wr_addr    = '0;
    bus.i_wr_data    = '0;
    bus.i_start      = 1'b0;
    bus.i_mode       = 2'b00;
    bus.i_resp_start = 1'b0;

    // Reset state
    tick();
    chk("rst_data", bus.o_data, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    tick();
    rstb = 1'b1;
    tick();

    // Load words 1..63; word 0 is written in the same cycle as the launch
    for (int n = 1; n < 64; n++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = 6'(n);
      bus.i_wr_data = 16'(16'h0100 + n);
      tick();
    end

    // Frame 1: mode 01, launch together with write of word 0
    bus.i_wr_addr = 6'd0;
    bus.i_wr_data = 16'h0100;
    bus.i_start   = 1'b1;
    bus.i_mode    = 2'b01;
    tick();
    bus.i_wr_en = 1'b0;
    bus.i_start = 1'b0;
    bus.i_mode  = 2'b10;
    chk("f1_cmd_busy", bus.o_busy, 1);
    chk("f1_pre_cmd_data", bus.o_data, 0);
    tick();
    chk("f1_cmd_word", bus.o_data, 16'h0001);
    for (int n = 0; n < 64; n++) begin
      tick();
      chk($sformatf("f1_sample%0d", n), bus.o_data, 16'h0100 + n);
      if (n == 5) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = 6'd3;
        bus.i_wr_data = 16'hBEEF;
        bus.i_start   = 1'b1;
        bus.i_mode    = 2'b11;
      end else begin
        bus.i_wr_en = 1'b0;
        bus.i_start = 1'b0;
      end
    end
    tick();
    chk("f1_wait_data", bus.o_data, 0);
    chk("f1_wait_busy", bus.o_busy, 1);
    tick();
    tick();
    tick();
    bus.i_resp_start = 1'b1;
    tick();
    bus.i_resp_start = 1'b0;
    chk("f1_done", bus.o_done, 1);
    chk("f1_done_timeout", bus.o_timeout, 0);
    chk("f1_done_data", bus.o_data, 0);
    tick();
    chk("f1_done_pulse_end", bus.o_done, 0);
    chk("f1_idle_busy", bus.o_busy, 0);

    // Mode 00 launch is ignored
    bus.i_start = 1'b1;
    bus.i_mode  = 2'b00;
    tick();
    chk("m00_busy", bus.o_busy, 0);
    tick();
    chk("m00_busy2", bus.o_busy, 0);
    chk("m00_data", bus.o_data, 0);

    // Frame 2: mode 10, response pulse only during SEND, then timeout
    bus.i_mode = 2'b10;
    tick();
    bus.i_start = 1'b0;
    chk("f2_busy", bus.o_busy, 1);
    tick();
    chk("f2_cmd_word", bus.o_data, 16'h0002);
    for (int n = 0; n < 64; n++) begin
      tick();
      chk($sformatf("f2_sample%0d", n), bus.o_data, 16'h0100 + n);
      bus.i_resp_start = (n == 5);
    end
    bus.i_resp_start = 1'b0;
    cnt = 0;
    while (bus.o_done !== 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk("f2_timeout_cycles", cnt, 1024);
    chk("f2_timeout_flag", bus.o_timeout, 1);
    tick();
    chk("f2_done_pulse_end", bus.o_done, 0);
    chk("f2_idle_busy", bus.o_busy, 0);
    tick();
    tick();
    chk("f2_timeout_sticky", bus.o_timeout, 1);

    // Frame 3: mode 11, response on the timeout cycle
    bus.i_start = 1'b1;
    bus.i_mode  = 2'b11;
    tick();
    bus.i_start = 1'b0;
    chk("f3_timeout_cleared", bus.o_timeout, 0);
    tick();
    chk("f3_cmd_word", bus.o_data, 16'h0003);
    for (int n = 0; n < 64; n++) tick();
    chk("f3_last_sample", bus.o_data, 16'h013F);
    for (int n = 0; n < 1023; n++) tick();
    chk("f3_no_early_done", bus.o_done, 0);
    bus.i_resp_start = 1'b1;
    tick();
    bus.i_resp_start = 1'b0;
    chk("f3_done", bus.o_done, 1);
    chk("f3_resp_wins", bus.o_timeout, 0);
    tick();
    tick();

    // Frame 4: reset at sample 20, then full restart
    bus.i_start = 1'b1;
    bus.i_mode  = 2'b01;
    tick();
    bus.i_start = 1'b0;
    tick();
    for (int n = 0; n <= 20; n++) tick();
    chk("f4_sample20", bus.o_data, 16'h0114);
    #2;
    rstb = 1'b0;
    #1;
    chk("f4_async_data", bus.o_data, 0);
    chk("f4_async_busy", bus.o_busy, 0);
    tick();
    rstb = 1'b1;
    seen_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.o_done === 1'b1) seen_done = 1'b1;
    end
    chk("f4_no_done_after_abort", seen_done, 0);
    chk("f4_idle_after_abort", bus.o_busy, 0);
    bus.i_start = 1'b1;
    bus.i_mode  = 2'b01;
    tick();
    bus.i_start = 1'b0;
    chk("f5_busy", bus.o_busy, 1);
    tick();
    chk("f5_cmd_word", bus.o_data, 16'h0001);
    for (int n = 0; n < 64; n++) begin
      tick();
      chk($sformatf("f5_sample%0d", n), bus.o_data, 16'h0100 + n);
    end
    tick();
    bus.i_resp_start = 1'b1;
    tick();
    bus.i_resp_start = 1'b0;
    chk("f5_done", bus.o_done, 1);
    tick();
    chk("f5_idle", bus.o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
